pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameters SHALL be:
- MUL_LAT, 4, mult busy cycles (>=1)
- DIV_LAT, 32, div busy cycles (>=1)
- CNT_W, 16, stall counter width
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- d_rs, d_rt  in  5 each  ID source register numbers
- d_use_rs, d_use_rt  in  1 each  ID instruction reads rs / rt
- e_wreg, e_m2reg  in  1 each  EX instruction writes a GPR / is a load
- e_GPR  in  5  EX destination register
- d_pcsource  in  2  ID next-PC select (0 = sequential)
- d_mdu_start  in  1  ID holds mult/div
- d_mdu_div  in  1  1 = div, 0 = mult
- d_mdu_read  in  1  ID holds mfhi/mflo
- wpc  out  1  PC write enable
- wpcir  out  1  IF/ID register write enable
- dbubble  out  1  load NOP into ID/EX
- flush_if  out  1  clear IF/ID
- mdu_go  out  1  one-cycle MDU start pulse
- mdu_busy  out  1  MDU operation in progress
- mdu_done  out  1  one-cycle result-ready pulse
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Function
REQ-003 load_use SHALL = e_wreg & e_m2reg & (e_GPR!=0) & ((d_use_rs & e_GPR==d_rs) | (d_use_rt & e_GPR==d_rt)).
REQ-004 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-005 mdu_stall SHALL = (state==BUSY) & (d_mdu_start | d_mdu_read).
REQ-006 stall SHALL = load_use | mdu_stall; wpc = wpcir = ~stall; dbubble = stall.
REQ-007 mdu_go SHALL = d_mdu_start & ~load_use & (state==IDLE | state==DONE), combinational.
REQ-008 On mdu_go the FSM SHALL enter BUSY with cnt loaded to (d_mdu_div ? DIV_LAT : MUL_LAT) - 1.
REQ-009 In BUSY, cnt SHALL decrement each cycle; when cnt==0 the FSM SHALL enter DONE on the next edge.
REQ-010 DONE SHALL last one cycle, then go to IDLE, or to BUSY if mdu_go is asserted that cycle.
REQ-011 mdu_busy SHALL = (state==BUSY); mdu_done SHALL = (state==DONE).
REQ-012 A mult with MUL_LAT=4 SHALL give mdu_busy for exactly 4 cycles, with mdu_done in the 5th cycle after mdu_go.
REQ-013 d_mdu_read in DONE or IDLE SHALL NOT stall.
REQ-014 stall_cnt SHALL increment by 1 on each edge where stall=1 and SHALL hold at all-ones (no wrap).
REQ-015 flush_if SHALL be governed by REQ-021.

Reset
REQ-016 While rst=0 at a rising edge, the next state SHALL be: state=IDLE, cnt=0, stall_cnt=0.
REQ-017 While rst=0, outputs SHALL be forced to: wpc=1, wpcir=1, dbubble=0, flush_if=0, mdu_go=0, mdu_busy=0, mdu_done=0.
REQ-018 Reset asserted mid-operation SHALL abort the MDU sequence with no mdu_done pulse.

Configuration
REQ-019 Macro BRANCH_FLUSH_EN SHALL select the branch policy.
REQ-020 When BRANCH_FLUSH_EN is undefined, flush_if SHALL be constant 0 (delay-slot semantics).
REQ-021 When BRANCH_FLUSH_EN is defined, flush_if SHALL = (d_pcsource!=0) & ~stall, squashing the fall-through instruction for one cycle.

Verification
REQ-022 e_wreg=1, e_m2reg=1, e_GPR=5, d_rs=5, d_use_rs=1 -> wpc=0, wpcir=0, dbubble=1 for one cycle; stall_cnt 0->1.
REQ-023 Same as REQ-022 with e_GPR=0 -> no stall; stall_cnt stays 0.
REQ-024 mult start (d_mdu_div=0) at cycle 0, d_mdu_read=1 at cycle 1 -> stall in cycles 1-4, mdu_done=1 in cycle 5, stall released in cycle 5.
REQ-025 div start, then rst=0 at cycle 10 -> state IDLE, mdu_busy=0, no mdu_done, stall_cnt=0.
REQ-026 BRANCH_FLUSH_EN defined, d_pcsource=2, no hazard -> flush_if=1; with load_use also active -> flush_if=0, dbubble=1.
REQ-027 Force 2^CNT_W+3 stalled cycles (CNT_W=4 build) -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/bubble controller: load-use interlock plus a multi-cycle MDU sequencer.
// Optional macro BRANCH_FLUSH_EN squashes the fall-through fetch on taken branches.
module pipe_stall_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic             d_use_rs,
  input  logic             d_use_rt,
  input  logic             e_wreg,
  input  logic             e_m2reg,
  input  logic [4:0]       e_GPR,
  input  logic [1:0]       d_pcsource,
  input  logic             d_mdu_start,
  input  logic             d_mdu_div,
  input  logic             d_mdu_read,
  output logic             wpc,
  output logic             wpcir,
  output logic             dbubble,
  output logic             flush_if,
  output logic             mdu_go,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int LW      = $clog2(MAX_LAT) + 1;
  localparam logic [LW-1:0] MUL_LOAD = LW'(MUL_LAT - 1);
  localparam logic [LW-1:0] DIV_LOAD = LW'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_next;
  logic [LW-1:0] cnt, cnt_next;
  logic          load_use, mdu_stall, stall;

  // Every hazard term is qualified by rst so outputs read as "run freely" during reset.
  assign load_use  = rst & e_wreg & e_m2reg & (e_GPR != 5'd0) &
                     ((d_use_rs & (e_GPR == d_rs)) | (d_use_rt & (e_GPR == d_rt)));
  assign mdu_stall = rst & (state == BUSY) & (d_mdu_start | d_mdu_read);
  assign stall     = load_use | mdu_stall;

  assign wpc      = ~stall;
  assign wpcir    = ~stall;
  assign dbubble  = stall;
  assign mdu_go   = rst & d_mdu_start & ~load_use & ((state == IDLE) | (state == DONE));
  assign mdu_busy = rst & (state == BUSY);
  assign mdu_done = rst & (state == DONE);

`ifdef BRANCH_FLUSH_EN
  assign flush_if = rst & (d_pcsource != 2'd0) & ~stall;
`else
  logic pcsource_unused;
  assign pcsource_unused = |d_pcsource;
  assign flush_if        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // DONE lasts one cycle; a start seen in DONE chains straight into the next operation.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (mdu_go) begin
          state_next = BUSY;
          cnt_next   = d_mdu_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        if (cnt == '0) state_next = DONE;
        else           cnt_next   = cnt - 1'b1;
      end
      DONE: begin
        if (mdu_go) begin
          state_next = BUSY;
          cnt_next   = d_mdu_div ? DIV_LOAD : MUL_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed testbench for pipe_stall_ctrl (built with CNT_W=4 so saturation is reachable).
module tb_pipe_stall_ctrl;

  localparam int TB_CNT_W = 4;

  logic                clk;
  logic                rst;
  logic [4:0]          d_rs, d_rt, e_GPR;
  logic                d_use_rs, d_use_rt, e_wreg, e_m2reg;
  logic [1:0]          d_pcsource;
  logic                d_mdu_start, d_mdu_div, d_mdu_read;
  logic                wpc, wpcir, dbubble, flush_if, mdu_go, mdu_busy, mdu_done;
  logic [TB_CNT_W-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  pipe_stall_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_GPR(e_GPR),
    .d_pcsource(d_pcsource),
    .d_mdu_start(d_mdu_start), .d_mdu_div(d_mdu_div), .d_mdu_read(d_mdu_read),
    .wpc(wpc), .wpcir(wpcir), .dbubble(dbubble), .flush_if(flush_if),
    .mdu_go(mdu_go), .mdu_busy(mdu_busy), .mdu_done(mdu_done),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic use_rs, input logic use_rt,
                               input logic wreg, input logic m2reg, input logic [4:0] gpr,
                               input logic [1:0] pcsrc, input logic start,
                               input logic div, input logic rd);
    d_rs = rs; d_rt = rt; d_use_rs = use_rs; d_use_rt = use_rt;
    e_wreg = wreg; e_m2reg = m2reg; e_GPR = gpr; d_pcsource = pcsrc;
    d_mdu_start = start; d_mdu_div = div; d_mdu_read = rd;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n;
    int done_seen;

    rst = 1'b0;
    clearInputs();
    step();
    // During reset a hazard and a start must not leak to the outputs
    applyStimulus(5, 0, 1, 0, 1, 1, 5, 0, 1, 0, 0);
    checkOutput("rst_wpc", wpc, 1);
    checkOutput("rst_wpcir", wpcir, 1);
    checkOutput("rst_dbubble", dbubble, 0);
    checkOutput("rst_flush", flush_if, 0);
    checkOutput("rst_go", mdu_go, 0);
    step();
    checkOutput("rst_busy", mdu_busy, 0);
    checkOutput("rst_done", mdu_done, 0);
    checkOutput("rst_cnt", stall_cnt, 0);
    clearInputs();
    rst = 1'b1;
    #1;
    checkOutput("idle_wpc", wpc, 1);

    // Load-use on rs: one-cycle stall, counter 0 -> 1
    applyStimulus(5, 0, 1, 0, 1, 1, 5, 0, 0, 0, 0);
    checkOutput("lu_wpc", wpc, 0);
    checkOutput("lu_wpcir", wpcir, 0);
    checkOutput("lu_dbubble", dbubble, 1);
    checkOutput("lu_cnt_before", stall_cnt, 0);
    step();
    clearInputs();
    checkOutput("lu_cnt_after", stall_cnt, 1);
    checkOutput("lu_released", wpc, 1);

    // Load-use on rt, and the same match with the rt read disabled
    applyStimulus(0, 7, 0, 1, 1, 1, 7, 0, 0, 0, 0);
    checkOutput("lu_rt", dbubble, 1);
    applyStimulus(0, 7, 0, 0, 1, 1, 7, 0, 0, 0, 0);
    checkOutput("lu_rt_unused", dbubble, 0);
    applyStimulus(5, 0, 1, 0, 1, 0, 5, 0, 0, 0, 0);
    checkOutput("non_load", dbubble, 0);

    // Destination r0 never interlocks
    applyStimulus(0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("r0_wpc", wpc, 1);
    step();
    checkOutput("r0_cnt", stall_cnt, 1);

    // A start blocked by a load-use must not launch the MDU
    applyStimulus(5, 0, 1, 0, 1, 1, 5, 0, 1, 0, 0);
    checkOutput("go_blocked", mdu_go, 0);

    // Branch policy
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
`ifdef BRANCH_FLUSH_EN
    checkOutput("flush_branch", flush_if, 1);
`else
    checkOutput("flush_branch", flush_if, 0);
`endif
    applyStimulus(5, 0, 1, 0, 1, 1, 5, 2, 0, 0, 0);
    checkOutput("flush_hazard", flush_if, 0);
    checkOutput("flush_hazard_bubble", dbubble, 1);

    // Mult at cycle 0, mfhi/mflo from cycle 1: stall 1-4, done in 5
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("mul_go", mdu_go, 1);
    checkOutput("mul_go_nostall", wpc, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("mul_busy_c%0d", i), mdu_busy, 1);
      checkOutput($sformatf("mul_stall_c%0d", i), dbubble, 1);
      checkOutput($sformatf("mul_nodone_c%0d", i), mdu_done, 0);
      step();
    end
    checkOutput("mul_done_c5", mdu_done, 1);
    checkOutput("mul_busy_c5", mdu_busy, 0);
    checkOutput("mul_release_c5", wpc, 1);
    checkOutput("mul_cnt", stall_cnt, 5);
    step();
    checkOutput("idle_read_nostall", dbubble, 0);
    checkOutput("done_one_cycle", mdu_done, 0);
    clearInputs();

    // Back-to-back: a start in DONE chains into BUSY
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step();
    clearInputs();
    for (int i = 0; i < 4; i++) step();
    checkOutput("chain_done", mdu_done, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("chain_go", mdu_go, 1);
    step();
    clearInputs();
    checkOutput("chain_busy", mdu_busy, 1);
    for (int i = 0; i < 4; i++) step();
    checkOutput("chain_done2", mdu_done, 1);
    step();
    checkOutput("chain_idle", mdu_busy | mdu_done, 0);

    // Full division length
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("div_go", mdu_go, 1);
    step();
    clearInputs();
    n = 0;
    while (mdu_busy && n < 50) begin
      n++;
      step();
    end
    checkOutput("div_busy_len", n, 32);
    checkOutput("div_done", mdu_done, 1);
    step();

    // Division aborted by reset at cycle 10
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step();
    clearInputs();
    for (int i = 1; i < 10; i++) step();
    checkOutput("abort_busy_before", mdu_busy, 1);
    rst = 1'b0;
    #1;
    checkOutput("abort_busy_forced", mdu_busy, 0);
    step();
    rst = 1'b1;
    #1;
    checkOutput("abort_busy_after", mdu_busy, 0);
    checkOutput("abort_cnt", stall_cnt, 0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (mdu_done) done_seen++;
      step();
    end
    checkOutput("abort_no_done", done_seen, 0);

    // Saturation of the 4-bit counter over 19 stalled cycles
    applyStimulus(5, 0, 1, 0, 1, 1, 5, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) step();
    checkOutput("sat_14", stall_cnt, 14);
    for (int i = 0; i < 5; i++) step();
    checkOutput("sat_19", stall_cnt, 15);
    clearInputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
